// File: rtl/fp_mul_disp_pkg.sv
// Shared types for the FP32 multiplier dispatcher: FSM states, request record
// and the canonical quiet NaN returned on a watchdog timeout.
package fp_mul_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // Tag field is sized for the widest tag any instance may use; narrower
  // tags are zero-extended on the way in and truncated on the way out.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [TAG_MAX_W-1:0] tag;
  } req_t;

endpackage

// File: rtl/fp_req_fifo.sv
// Synchronous request FIFO of req_t. A push at full is refused even when a
// pop happens in the same cycle, so the producer only ever sees !full.
module fp_req_fifo
  import fp_mul_disp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  req_t                   push_data,
  input  logic                   pop,
  output req_t                   pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  req_t        mem_q [DEPTH];
  req_t        mem_d [DEPTH];
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset discards any queued entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fp_mul_dispatcher.sv
// Front-end for the FP32 multiplier: queues tagged operand pairs, issues one
// op at a time (mul_en pulse), waits for mul_rdy under a watchdog and returns
// the result on a valid/ready port. A watchdog expiry answers with a quiet NaN
// flagged as an error and halts issue (hung) until reset.
// Optional: define FP_MUL_DISP_STATS_EN for saturating op / NaN counters.
module fp_mul_dispatcher
  import fp_mul_disp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_en,
  input  logic [31:0]      mul_result,
  input  logic             mul_rdy,
  input  logic             mul_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_nan,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             hung,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_nans
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic [31:0]          a_q, a_d, b_q, b_d, res_q, res_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 nan_q, nan_d, err_q, err_d, hung_q, hung_d;

  req_t                 push_req, pop_req;
  logic                 fifo_full, fifo_empty, fifo_pop;
  // Occupancy is only of interest for debug visibility.
  logic [$clog2(DEPTH):0] fifo_cnt_unused;
  // Full-width tag as stored; only the low TAG_W bits are meaningful.
  logic [TAG_MAX_W-1:0] pop_tag_unused;

  assign push_req       = '{a: in_a, b: in_b, tag: TAG_MAX_W'(in_tag)};
  assign pop_tag_unused = pop_req.tag;
  assign fifo_pop       = (state_q == IDLE) && !fifo_empty && !hung_q;
  // Held low during reset so nothing is accepted into a FIFO being cleared.
  assign in_ready       = !reset && !fifo_full;

  fp_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (pop_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt_unused)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty && !hung_q) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mul_rdy || (wdog_q == WD_LAST)) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: start pulse only in ISSUE, response valid only in HOLD.
  always_comb begin
    mul_en    = (state_q == ISSUE);
    out_valid = (state_q == HOLD);
  end

  // Datapath: operand/tag load on pop, watchdog, result capture or timeout.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    tag_d  = tag_q;
    wdog_d = wdog_q;
    res_d  = res_q;
    nan_d  = nan_q;
    err_d  = err_q;
    hung_d = hung_q;
    case (state_q)
      IDLE: if (fifo_pop) begin
        a_d   = pop_req.a;
        b_d   = pop_req.b;
        tag_d = pop_tag_unused[TAG_W-1:0];
      end
      ISSUE: wdog_d = '0;
      WAIT: begin
        // A real completion on the last watchdog cycle still wins.
        if (mul_rdy) begin
          res_d = mul_result;
          nan_d = mul_nan;
          err_d = 1'b0;
        end else if (wdog_q == WD_LAST) begin
          res_d  = FP32_QNAN;
          nan_d  = 1'b1;
          err_d  = 1'b1;
          hung_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      wdog_q <= '0;
      res_q  <= '0;
      nan_q  <= 1'b0;
      err_q  <= 1'b0;
      hung_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      tag_q  <= tag_d;
      wdog_q <= wdog_d;
      res_q  <= res_d;
      nan_q  <= nan_d;
      err_q  <= err_d;
      hung_q <= hung_d;
    end
  end

  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign out_result = res_q;
  assign out_nan    = nan_q;
  assign out_err    = err_q;
  assign out_tag    = tag_q;
  assign hung       = hung_q;

`ifdef FP_MUL_DISP_STATS_EN
  logic [CNT_W-1:0] ops_q, ops_d, nans_q, nans_d;

  // Saturating counters of returned responses and NaN responses.
  always_comb begin
    ops_d  = ops_q;
    nans_d = nans_q;
    if (out_valid && out_ready) begin
      if (ops_q != '1) ops_d = ops_q + CNT_W'(1);
      if (nan_q && (nans_q != '1)) nans_d = nans_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_q  <= '0;
      nans_q <= '0;
    end else begin
      ops_q  <= ops_d;
      nans_q <= nans_d;
    end
  end

  assign stat_ops  = ops_q;
  assign stat_nans = nans_q;
`else
  assign stat_ops  = '0;
  assign stat_nans = '0;
`endif

endmodule

// File: tb/tb_fp_mul_dispatcher.sv
// Self-checking bench for fp_mul_dispatcher: a behavioural multiplier stub,
// a queue-based scoreboard of expected responses in request order, directed
// scenarios plus a randomized traffic phase.
module tb_fp_mul_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 32;
  localparam int CNT_W   = 16;

  logic             clk, reset;
  logic             in_valid, in_ready;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      mul_a, mul_b, mul_result;
  logic             mul_en, mul_rdy, mul_nan;
  logic             out_valid, out_ready, out_nan, out_err, hung;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] stat_ops, stat_nans;

  fp_mul_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
    .mul_result(mul_result), .mul_rdy(mul_rdy), .mul_nan(mul_nan),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nan(out_nan), .out_err(out_err), .out_tag(out_tag), .hung(hung),
    .stat_ops(stat_ops), .stat_nans(stat_nans)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      res;
    logic             nan;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             expq[$];
  logic [TAG_W-1:0] rtags[$];
  int               n_vec = 0, n_err = 0;
  int               n_resp = 0, en_cnt = 0;
  bit               sb_on = 1'b1, stub_hang = 1'b0, pend = 1'b0;
  int               lat_lo = 1, lat_hi = 3, spur_pct = 0, stub_cnt = 0;
  logic [31:0]      last_res, stub_a, stub_b;
  logic             last_nan, last_err;
  logic [TAG_W-1:0] last_tag;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference FP32 product: NaN in -> quiet NaN out; operands are kept in a
  // normal exponent range so no overflow/denormal handling is needed.
  function automatic logic [32:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    bit          an, bn;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (an || bn) return {1'b1, 32'h7FC0_0000};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else       m = p[45:23];
    return {1'b0, a[31] ^ b[31], 8'(e), m};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [22:0] mant;
    mant = 23'($urandom);
    if ($urandom_range(9) == 0) return {1'($urandom), 8'hFF, mant | 23'h1};
    return {1'($urandom), 8'($urandom_range(150, 100)), mant};
  endfunction

  // Multiplier stub: answers each mul_en after a random latency; may also
  // inject stray mul_rdy pulses while nothing is outstanding.
  initial begin
    logic [32:0] r;
    mul_rdy = 1'b0; mul_result = '0; mul_nan = 1'b0;
    forever begin
      @(negedge clk);
      mul_rdy = 1'b0;
      if (reset) pend = 1'b0;
      else if (pend) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          r = fp_model(stub_a, stub_b);
          mul_nan = r[32]; mul_result = r[31:0]; mul_rdy = 1'b1; pend = 1'b0;
        end
      end else if (!stub_hang && ($urandom_range(99) < 32'(spur_pct))) begin
        mul_rdy = 1'b1; mul_result = $urandom; mul_nan = 1'($urandom);
      end
      if (mul_en) begin
        en_cnt++;
        if (sb_on && expq.size() > 0) begin
          chk("issue_a", mul_a, expq[0].a);
          chk("issue_b", mul_b, expq[0].b);
        end
        if (!stub_hang) begin
          pend = 1'b1; stub_a = mul_a; stub_b = mul_b;
          stub_cnt = $urandom_range(lat_hi, lat_lo);
        end
      end
    end
  end

  // Called at a negedge with inputs set; accounts for the handshakes that
  // the coming posedge will perform, then advances to the next negedge.
  task automatic tick(output bit acc);
    exp_t e;
    logic [32:0] r;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_resp++;
      last_res = out_result; last_nan = out_nan; last_err = out_err; last_tag = out_tag;
      rtags.push_back(out_tag);
      if (sb_on) begin
        chk("sb_pending", (expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("sb_result", out_result, e.res);
          chk("sb_nan", out_nan, e.nan);
          chk("sb_err", out_err, 0);
          chk("sb_tag", out_tag, e.tag);
        end
      end
    end
    if (acc) begin
      r = fp_model(in_a, in_b);
      e.a = in_a; e.b = in_b; e.res = r[31:0]; e.nan = r[32]; e.tag = in_tag;
      expq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bit acc = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    for (int i = 0; i < 60; i++) begin
      tick(acc);
      if (acc) break;
    end
    chk("send_accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target, input int budget);
    bit acc;
    for (int i = 0; i < budget; i++) begin
      if (n_resp >= target) break;
      tick(acc);
    end
    chk("resp_in_time", (n_resp >= target), 1);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_mul_en"}, mul_en, 0);
    chk({pfx, "_mul_a"}, mul_a, 0);
    chk({pfx, "_mul_b"}, mul_b, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_result"}, out_result, 0);
    chk({pfx, "_out_flags"}, {out_nan, out_err, hung}, 0);
    chk({pfx, "_out_tag"}, out_tag, 0);
    chk({pfx, "_stats"}, {stat_ops, stat_nans}, 0);
  endtask

  // Asserts reset at a negedge; outputs are checked one cycle later.
  task automatic reset_dut(input string pfx);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_zero(pfx);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expq.delete();
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int idx, e0, r0, t_en;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    @(negedge clk);
    reset_dut("rst");

    // Directed ops: 1.5*2, NaN*1, 3*4, -1*2
    out_ready = 1'b1;
    e0 = en_cnt; r0 = n_resp;
    send(32'h3FC0_0000, 32'h4000_0000, 4'd3);
    wait_resp(r0 + 1, 100);
    chk("t1_result", last_res, 32'h4040_0000);
    chk("t1_nan", last_nan, 0);
    chk("t1_tag", last_tag, 3);
    chk("t1_one_issue", en_cnt - e0, 1);
    send(32'h7FC0_0000, 32'h3F80_0000, 4'd5);
    wait_resp(r0 + 2, 100);
    chk("t2_result", last_res, 32'h7FC0_0000);
    chk("t2_nan_err", {last_nan, last_err}, 2'b10);
    send(32'h4040_0000, 32'h4080_0000, 4'd7);
    wait_resp(r0 + 3, 100);
    chk("t_mul12", last_res, 32'h4140_0000);
    send(32'hBF80_0000, 32'h4000_0000, 4'd1);
    wait_resp(r0 + 4, 100);
    chk("t_mulneg2", last_res, 32'hC000_0000);
`ifdef FP_MUL_DISP_STATS_EN
    chk("stat_ops", stat_ops, 4);
    chk("stat_nans", stat_nans, 1);
`else
    chk("stat_ops", stat_ops, 0);
    chk("stat_nans", stat_nans, 0);
`endif

    // Backpressure: one op parks in HOLD, DEPTH more fill the FIFO.
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 6);
      in_a = rand_fp(); in_b = rand_fp(); in_tag = 4'(idx);
      tick(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("t3_accepted", idx, 5);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_holding", out_valid, 1);
    r0 = n_resp; rtags.delete(); out_ready = 1'b1;
    wait_resp(r0 + 5, 200);
    chk("t3_responses", rtags.size(), 5);
    for (int i = 0; i < rtags.size(); i++) chk("t3_order", rtags[i], 4'(i));

    // Randomized traffic with stray mul_rdy pulses.
    lat_lo = 1; lat_hi = 8; spur_pct = 20; idx = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 6000 && idx < 200; c++) begin
      if (!in_valid && $urandom_range(99) < 70) begin
        in_valid = 1'b1; in_a = rand_fp(); in_b = rand_fp(); in_tag = 4'($urandom);
      end
      out_ready = ($urandom_range(99) < 60);
      tick(acc);
      if (acc) begin idx++; in_valid = 1'b0; end
    end
    in_valid = 1'b0; out_ready = 1'b1; spur_pct = 0;
    chk("rand_issued", idx, 200);
    for (int c = 0; c < 500 && expq.size() != 0; c++) tick(acc);
    chk("rand_drained", expq.size(), 0);

    // Reset while the multiplier is busy: queued work is dropped.
    lat_lo = 20; lat_hi = 20;
    send(rand_fp(), rand_fp(), 4'd1);
    send(rand_fp(), rand_fp(), 4'd2);
    send(rand_fp(), rand_fp(), 4'd3);
    tick(acc); tick(acc);
    chk("t5_in_wait", {pend, out_valid}, 2'b10);
    reset_dut("t5");
    lat_lo = 2; lat_hi = 2;
    e0 = en_cnt; r0 = n_resp;
    for (int c = 0; c < 10; c++) tick(acc);
    chk("t5_no_issue", en_cnt - e0, 0);
    chk("t5_no_resp", n_resp - r0, 0);
    send(32'h3FC0_0000, 32'h4000_0000, 4'd6);
    wait_resp(r0 + 1, 100);
    chk("t5_result", last_res, 32'h4040_0000);
    chk("t5_tag", last_tag, 6);

    // Watchdog: multiplier never answers.
    reset_dut("t4rst");
    stub_hang = 1'b1; sb_on = 1'b0; out_ready = 1'b0;
    e0 = en_cnt; t_en = -1;
    send(32'h4000_0000, 32'h4000_0000, 4'd9);
    for (int c = 0; c < 100; c++) begin
      if (mul_en && t_en < 0) t_en = cyc;
      if (out_valid) break;
      tick(acc);
    end
    chk("t4_issued", (t_en >= 0), 1);
    chk("t4_latency", cyc - t_en, TIMEOUT + 1);
    chk("t4_result", out_result, 32'h7FC0_0000);
    chk("t4_nan_err", {out_nan, out_err}, 2'b11);
    chk("t4_tag", out_tag, 9);
    chk("t4_hung", hung, 1);
    out_ready = 1'b1;
    tick(acc);
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 6);
      in_a = rand_fp(); in_b = rand_fp(); in_tag = 4'(idx);
      tick(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("t4_queued", idx, DEPTH);
    chk("t4_no_reissue", en_cnt - e0, 1);
    chk("t4_idle_out", out_valid, 0);
    chk("t4_still_hung", hung, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard against a wedged run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
